// File: rtl/mat_div_seq.sv
// Element-wise divider sequencer: walks NUM_ELEM (numerator, divisor) pairs out of
// the register file, divides each bit-serially and writes the quotient back.
// Latency: WIDTH+2 cycles per element; done pulses NUM_ELEM*(WIDTH+2)+1 cycles after start.
// Backpressure: none; start is only accepted in IDLE and ignored while busy (no queueing).
//
// Ports:
//   clk, rst_n         : clock, synchronous active-low reset
//   start              : begin a run (sampled only while idle)
//   busy, done         : busy in every non-idle state; done is a one-cycle end-of-run pulse
//   div_by_zero        : sticky until the next accepted start; set if any divisor was 0
//   ra_num/ra_den      : rf read addresses (combinational rf reads rd_num/rd_den)
//   reg_write, wa, wd  : rf write port; wa/wd hold their last value outside WRITE
//
// Optional build macro MAT_DIV_SIGNED_EN: operands are two's complement, quotient
// truncates toward zero. Without it, operands and results are unsigned.
// WIDTH must be at least 2.

module mat_div_seq #(
  parameter int WIDTH    = 32,
  parameter int AW       = 4,
  parameter int NUM_ELEM = 4,
  parameter int NUM_BASE = 0,
  parameter int DEN_BASE = 4,
  parameter int Q_BASE   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [AW-1:0]    ra_num,
  output logic [AW-1:0]    ra_den,
  input  logic [WIDTH-1:0] rd_num,
  input  logic [WIDTH-1:0] rd_den,
  output logic             reg_write,
  output logic [AW-1:0]    wa,
  output logic [WIDTH-1:0] wd
);

  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [AW-1:0] IDX_LAST = AW'(NUM_ELEM - 1);
  localparam logic [AW-1:0] NUM_B    = AW'(NUM_BASE);
  localparam logic [AW-1:0] DEN_B    = AW'(DEN_BASE);
  localparam logic [AW-1:0] Q_B      = AW'(Q_BASE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DIV,
    S_WRITE,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [AW-1:0]    idx;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem;    // partial remainder with the next dividend bit already shifted in
  logic [WIDTH-1:0] quo;    // dividend bits shift out of the top, quotient bits enter the bottom
  logic [WIDTH-1:0] den;
  logic             dbz;
  logic [AW-1:0]    wa_q;
  logic [WIDTH-1:0] wd_q;

`ifdef MAT_DIV_SIGNED_EN
  logic             num_neg;
  logic             q_neg;
  logic             den_zero;
`endif

  logic [WIDTH:0]   den_ext;
  logic [WIDTH:0]   rem_sub;
  logic [WIDTH:0]   rem_nx;
  logic             ge;
  logic [WIDTH-1:0] q_nx;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] num_mag;
  logic [WIDTH-1:0] den_mag;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and control outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nx  = state;
    busy      = 1'b1;
    done      = 1'b0;
    reg_write = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nx = S_READ;
        end
      end
      S_READ: begin
        state_nx = S_DIV;
      end
      S_DIV: begin
        if (cnt == CNT_LAST) begin
          state_nx = S_WRITE;
        end
      end
      S_WRITE: begin
        // A reset landing on the WRITE cycle must not commit the element.
        reg_write = rst_n;
        state_nx  = (idx == IDX_LAST) ? S_DONE : S_READ;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Division step and operand conditioning
  // ---------------------------------------------------------------------------
  always_comb begin
    den_ext = {1'b0, den};
    rem_sub = rem - den_ext;
    // Explicit compare (not the borrow bit) so a zero divisor yields all-ones.
    ge      = (rem >= den_ext);
    rem_nx  = ((ge ? rem_sub : rem) << 1) | {{WIDTH{1'b0}}, quo[WIDTH-1]};
    q_nx    = {quo[WIDTH-2:0], ge};

`ifdef MAT_DIV_SIGNED_EN
    num_mag = rd_num[WIDTH-1] ? (~rd_num + 1'b1) : rd_num;
    den_mag = rd_den[WIDTH-1] ? (~rd_den + 1'b1) : rd_den;
    if (den_zero) begin
      // Saturate toward the sign of the numerator.
      q_fin = num_neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else if (q_neg) begin
      q_fin = ~q_nx + 1'b1;
    end else begin
      q_fin = q_nx;
    end
`else
    num_mag = rd_num;
    den_mag = rd_den;
    q_fin   = q_nx;
`endif
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx      <= '0;
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      den      <= '0;
      dbz      <= 1'b0;
      wa_q     <= '0;
      wd_q     <= '0;
`ifdef MAT_DIV_SIGNED_EN
      num_neg  <= 1'b0;
      q_neg    <= 1'b0;
      den_zero <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            idx <= '0;
            dbz <= 1'b0;
          end
        end
        S_READ: begin
          // rf reads are combinational; operands are captured as this cycle ends.
          rem <= {{WIDTH{1'b0}}, num_mag[WIDTH-1]};
          quo <= {num_mag[WIDTH-2:0], 1'b0};
          den <= den_mag;
          cnt <= '0;
          if (rd_den == '0) begin
            dbz <= 1'b1;
          end
`ifdef MAT_DIV_SIGNED_EN
          num_neg  <= rd_num[WIDTH-1];
          q_neg    <= rd_num[WIDTH-1] ^ rd_den[WIDTH-1];
          den_zero <= (rd_den == '0);
`endif
        end
        S_DIV: begin
          rem <= rem_nx;
          quo <= q_nx;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            // Present the finished quotient and its address for the WRITE cycle.
            wa_q <= Q_B + idx;
            wd_q <= q_fin;
          end
        end
        S_WRITE: begin
          if (idx != IDX_LAST) begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign ra_num      = NUM_B + idx;
  assign ra_den      = DEN_B + idx;
  assign wa          = wa_q;
  assign wd          = wd_q;
  assign div_by_zero = dbz;

endmodule

// File: tb/tb_mat_div_seq.sv
// Directed bench for mat_div_seq: a behavioural 16x32 register file feeds the
// default-configured sequencer, and a second instance with the quotient region
// overlaid on the numerators exercises read-after-write ordering.

module tb_mat_div_seq;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start;
  logic        start2;

  logic        busy, done, dbz, reg_write;
  logic [3:0]  ra_num, ra_den, wa;
  logic [31:0] rd_num, rd_den, wd;

  logic        busy2, done2, dbz2, reg_write2;
  logic [3:0]  ra_num2, ra_den2, wa2;
  logic [31:0] rd_num2, rd_den2, wd2;

  logic [31:0] rf  [16];
  logic [31:0] rf2 [16];

  logic        pre_we  = 1'b0;
  logic        pre_sel = 1'b0;
  logic [3:0]  pre_wa  = 4'd0;
  logic [31:0] pre_wd  = 32'd0;

  int          checks  = 0;
  int          fails   = 0;
  int          wr_cnt  = 0;
  int          done_cnt = 0;
  int          dbl_cnt = 0;
  logic        prev_rw = 1'b0;

`ifdef MAT_DIV_SIGNED_EN
  localparam logic [31:0] EXP_R9 = 32'h0000_0000;   // -1 / 16 truncates to 0
  localparam logic [31:0] EXP_DZ = 32'h7FFF_FFFF;   // 55 / 0 saturates positive
`else
  localparam logic [31:0] EXP_R9 = 32'h0FFF_FFFF;
  localparam logic [31:0] EXP_DZ = 32'hFFFF_FFFF;
`endif

  assign rd_num  = rf[ra_num];
  assign rd_den  = rf[ra_den];
  assign rd_num2 = rf2[ra_num2];
  assign rd_den2 = rf2[ra_den2];

  mat_div_seq u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .div_by_zero (dbz),
    .ra_num      (ra_num),
    .ra_den      (ra_den),
    .rd_num      (rd_num),
    .rd_den      (rd_den),
    .reg_write   (reg_write),
    .wa          (wa),
    .wd          (wd)
  );

  mat_div_seq #(.NUM_ELEM(2), .Q_BASE(0)) u_ovl (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start2),
    .busy        (busy2),
    .done        (done2),
    .div_by_zero (dbz2),
    .ra_num      (ra_num2),
    .ra_den      (ra_den2),
    .rd_num      (rd_num2),
    .rd_den      (rd_den2),
    .reg_write   (reg_write2),
    .wa          (wa2),
    .wd          (wd2)
  );

  // Register file write port plus event counters, all on the rf write edge.
  always @(posedge clk) begin
    if (pre_we) begin
      if (pre_sel) rf2[pre_wa] <= pre_wd;
      else         rf[pre_wa]  <= pre_wd;
    end
    if (reg_write) begin
      rf[wa] <= wd;
      wr_cnt <= wr_cnt + 1;
    end
    if (reg_write2) begin
      rf2[wa2] <= wd2;
    end
    if (reg_write && prev_rw) dbl_cnt <= dbl_cnt + 1;
    prev_rw <= reg_write;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rf_set(input logic sel, input logic [3:0] a, input logic [31:0] d);
    pre_we  = 1'b1;
    pre_sel = sel;
    pre_wa  = a;
    pre_wd  = d;
    step(1);
    pre_we  = 1'b0;
  endtask

  // Leaves the bench in cycle s+1 (the READ cycle of element 0).
  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (!done && k < 300) begin
      step(1);
      k++;
    end
    check_eq(tag, 32'(done), 32'd1);
    step(1);
  endtask

  logic [31:0] init_v [8];
  logic [31:0] exp1   [4];
  int          wr0, dn0, db0, k2;

  initial begin
    init_v = '{32'd100, 32'hFFFF_FFFF, 32'd5, 32'd42, 32'd7, 32'd16, 32'd9, 32'd1};
    exp1   = '{32'd14, EXP_R9, 32'd0, 32'd42};
    rst_n  = 1'b0;
    start  = 1'b0;
    start2 = 1'b0;
    step(3);

    // Reset values
    check_eq("rst_busy",  32'(busy),      32'd0);
    check_eq("rst_done",  32'(done),      32'd0);
    check_eq("rst_dbz",   32'(dbz),       32'd0);
    check_eq("rst_rw",    32'(reg_write), 32'd0);
    check_eq("rst_wa",    32'(wa),        32'd0);
    check_eq("rst_wd",    wd,             32'd0);
    check_eq("rst_ranum", 32'(ra_num),    32'd0);
    check_eq("rst_raden", 32'(ra_den),    32'd4);
    rst_n = 1'b1;
    step(1);

    // Basic run with exact timing and two ignored start pulses
    for (int i = 0; i < 8; i++) rf_set(1'b0, 4'(i), init_v[i]);
    wr0 = wr_cnt;
    dn0 = done_cnt;
    db0 = dbl_cnt;
    pulse_start();                                       // cycle s+1
    check_eq("t1_busy_s1", 32'(busy), 32'd1);
    step(33);                                            // s+34: WRITE of element 0
    check_eq("t1_rw_s34", 32'(reg_write), 32'd1);
    check_eq("t1_wa_s34", 32'(wa),        32'd8);
    check_eq("t1_wd_s34", wd,             32'd14);
    step(6);                                             // s+40
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(59);                                            // s+100
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(35);                                            // s+136
    check_eq("t1_done_s136", 32'(done), 32'd0);
    check_eq("t1_busy_s136", 32'(busy), 32'd1);
    step(1);                                             // s+137
    check_eq("t1_done_s137", 32'(done), 32'd1);
    check_eq("t1_busy_s137", 32'(busy), 32'd1);
    step(1);                                             // s+138
    check_eq("t1_busy_s138", 32'(busy), 32'd0);
    check_eq("t1_done_s138", 32'(done), 32'd0);
    for (int i = 0; i < 4; i++) check_eq($sformatf("t1_rf%0d", 8 + i), rf[8 + i], exp1[i]);
    check_eq("t1_dbz",     32'(dbz),          32'd0);
    check_eq("t1_writes",  32'(wr_cnt - wr0), 32'd4);
    check_eq("t1_dones",   32'(done_cnt - dn0), 32'd1);
    check_eq("t1_rw_long", 32'(dbl_cnt - db0), 32'd0);

    // Zero divisor: saturated quotient and sticky flag
    rf_set(1'b0, 4'd4, 32'd0);
    rf_set(1'b0, 4'd0, 32'd55);
    pulse_start();
    wait_done("t2_done");
    check_eq("t2_rf8", rf[8], EXP_DZ);
    check_eq("t2_dbz", 32'(dbz), 32'd1);
    step(3);
    check_eq("t2_dbz_hold", 32'(dbz), 32'd1);

    // Flag clears on the next accepted start
    rf_set(1'b0, 4'd4, 32'd7);
    pulse_start();
    check_eq("t3_dbz_clr", 32'(dbz), 32'd0);
    wait_done("t3_done");
    check_eq("t3_rf8", rf[8], 32'd7);
    check_eq("t3_dbz", 32'(dbz), 32'd0);

    // Reset during DIV of element 2 abandons it
    rf_set(1'b0, 4'd0,  32'd70);
    rf_set(1'b0, 4'd2,  32'd90);
    rf_set(1'b0, 4'd10, 32'hDEAD_BEEF);
    wr0 = wr_cnt;
    pulse_start();                                       // s+1
    step(79);                                            // s+80
    rst_n = 1'b0;
    step(1);                                             // s+81
    check_eq("t4_busy_rst", 32'(busy),      32'd0);
    check_eq("t4_rw_rst",   32'(reg_write), 32'd0);
    rst_n = 1'b1;
    step(100);
    check_eq("t4_rf10_kept", rf[10], 32'hDEAD_BEEF);
    check_eq("t4_rf8",       rf[8],  32'd10);
    check_eq("t4_rf9",       rf[9],  EXP_R9);
    check_eq("t4_writes",    32'(wr_cnt - wr0), 32'd2);
    pulse_start();
    wait_done("t4_rerun_done");
    check_eq("t4_rf10_new", rf[10], 32'd10);

    // Quotients written over the numerator region
    rf_set(1'b1, 4'd0, 32'd81);
    rf_set(1'b1, 4'd4, 32'd3);
    rf_set(1'b1, 4'd1, 32'd10);
    rf_set(1'b1, 4'd5, 32'd2);
    start2 = 1'b1;
    step(1);
    start2 = 1'b0;                                       // s+1
    step(34);                                            // s+35
    check_eq("t5_rf0_e0", rf2[0], 32'd27);
    check_eq("t5_rf1_e0", rf2[1], 32'd10);
    k2 = 0;
    while (!done2 && k2 < 300) begin
      step(1);
      k2++;
    end
    check_eq("t5_done", 32'(done2), 32'd1);
    step(1);
    check_eq("t5_rf1", rf2[1], 32'd5);
    check_eq("t5_rf0", rf2[0], 32'd27);

`ifdef MAT_DIV_SIGNED_EN
    // Signed operands
    rf_set(1'b0, 4'd0, 32'hFFFF_FF9C);                   // -100
    rf_set(1'b0, 4'd4, 32'd7);
    rf_set(1'b0, 4'd1, 32'h8000_0000);
    rf_set(1'b0, 4'd5, 32'hFFFF_FFFF);
    rf_set(1'b0, 4'd2, 32'hFFFF_FFFB);                   // -5
    rf_set(1'b0, 4'd6, 32'd0);
    pulse_start();
    wait_done("t6_done");
    check_eq("t6_neg",    rf[8],  32'hFFFF_FFF2);
    check_eq("t6_minm1",  rf[9],  32'h8000_0000);
    check_eq("t6_negdz",  rf[10], 32'h8000_0000);
    check_eq("t6_pos",    rf[11], 32'd42);
    check_eq("t6_dbz",    32'(dbz), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
